// File: rtl/eight_bit_piso_shifter_if.sv
// Load/serial bundle for the 8-bit serial link transmitter.
//   d          : parallel word offered for transmission
//   load_valid : d holds a word to send
//   load_ready : transmitter can take a word this cycle
//   sdata      : serial data bit
//   sframe     : high while sdata carries a data or parity bit
//   sdone      : one-cycle pulse after the last serial bit
//   busy       : transmitter is not idle
// master = word source / link observer, slave = transmitter.
interface eight_bit_piso_shifter_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] d;
   logic             load_valid;
   logic             load_ready;
   logic             sdata;
   logic             sframe;
   logic             sdone;
   logic             busy;

   modport master (
      output d, load_valid,
      input  load_ready, sdata, sframe, sdone, busy
   );

   modport slave (
      input  d, load_valid,
      output load_ready, sdata, sframe, sdone, busy
   );
endinterface

// File: rtl/eight_bit_piso_shifter.sv
// Parallel-in, serial-out transmitter for the 8-bit serial link.
// Takes one WIDTH-bit word on a valid/ready handshake, then sends it one bit
// per clock with a framing strobe, an optional parity bit and a done pulse.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of eight_bit_piso_shifter_if (d, load_valid in;
//             load_ready, sdata, sframe, sdone, busy out)
// All outputs decode registered state only; no input reaches an output
// combinationally.
//
// state | meaning
// IDLE  | waiting for load_valid, load_ready=1
// SHIFT | sending data bits, head of shift register on sdata
// PAR   | sending the parity bit captured at accept
// DONE  | one-cycle sdone pulse, then back to IDLE
module eight_bit_piso_shifter #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   eight_bit_piso_shifter_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             par_q, par_d;
   logic             head_bit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      case (state_q)
         IDLE: begin
            if (bus.load_valid) begin
               shift_d = bus.d;
               // Parity is taken from d at accept so it never depends on
               // how far the shift register has advanced.
               par_d   = (^bus.d) ^ PARITY_ODD;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
            if (cnt_q == CNT_LAST) begin
               state_d = PARITY_EN ? PAR : DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PAR:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign head_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

   assign bus.load_ready = (state_q == IDLE);
   assign bus.busy       = (state_q != IDLE);
   assign bus.sframe     = (state_q == SHIFT) || (state_q == PAR);
   assign bus.sdone      = (state_q == DONE);
   assign bus.sdata      = (state_q == SHIFT) ? head_bit :
                           (state_q == PAR)   ? par_q    : 1'b0;
endmodule

// File: tb/tb_eight_bit_piso_shifter.sv
module tb_eight_bit_piso_shifter;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // unit 0: MSB first, no parity; 1: LSB first; 2: even parity; 3: odd parity
   logic [7:0] d_s [4];
   logic [3:0] lv_s;
   logic [3:0] rdy_w, sdata_w, sframe_w, sdone_w, busy_w;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      int         unit;
      logic [7:0] word;
   } exp_t;
   exp_t sb_q[$];

   for (genvar g = 0; g < 4; g++) begin : gen_u
      localparam bit MF = (g != 1);
      localparam bit PE = (g >= 2);
      localparam bit PO = (g == 3);
      eight_bit_piso_shifter_if #(.WIDTH(8)) ifc ();
      assign ifc.d          = d_s[g];
      assign ifc.load_valid = lv_s[g];
      assign rdy_w[g]    = ifc.load_ready;
      assign sdata_w[g]  = ifc.sdata;
      assign sframe_w[g] = ifc.sframe;
      assign sdone_w[g]  = ifc.sdone;
      assign busy_w[g]   = ifc.busy;
      eight_bit_piso_shifter #(
         .WIDTH(8), .MSB_FIRST(MF), .PARITY_EN(PE), .PARITY_ODD(PO)
      ) u_dut (
         .clk     (clk),
         .reset_n (reset_n),
         .bus     (ifc)
      );
      always @(posedge clk)
         if (reset_n && ifc.load_ready)
            assert (!$isunknown(ifc.load_valid))
               else $error("unit %0d: load_valid unknown while idle", g);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int frame_len(input int u);
      return (u >= 2) ? 9 : 8;
   endfunction

   // Expected serial bits, first bit sent ends up in the highest used position.
   function automatic logic [15:0] model_bits(input int u, input logic [7:0] w);
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < 8; i++)
         v = {v[14:0], (u != 1) ? w[7-i] : w[i]};
      if (u >= 2)
         v = {v[14:0], (^w) ^ (u == 3)};
      return v;
   endfunction

   // Serial monitor / scoreboard consumer
   initial begin
      logic [15:0] bits_q [4];
      int          nbits  [4];
      logic [3:0]  prev_frame;
      exp_t        e;
      prev_frame = '0;
      for (int u = 0; u < 4; u++) begin
         bits_q[u] = '0;
         nbits[u]  = 0;
      end
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_frame = '0;
            for (int u = 0; u < 4; u++) begin
               bits_q[u] = '0;
               nbits[u]  = 0;
            end
         end else begin
            for (int u = 0; u < 4; u++) begin
               if (sframe_w[u]) begin
                  bits_q[u] = {bits_q[u][14:0], sdata_w[u]};
                  nbits[u]++;
               end else begin
                  chk("sdata_unframed", {31'd0, sdata_w[u]}, 32'd0);
               end
               if (sdone_w[u]) begin
                  chk("sdone_after_bit", {31'd0, prev_frame[u]}, 32'd1);
                  chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
                  if (sb_q.size() != 0) begin
                     e = sb_q.pop_front();
                     chk("sb_unit", e.unit, u);
                     chk("frame_bits", {16'd0, bits_q[u]}, {16'd0, model_bits(u, e.word)});
                     chk("frame_len", nbits[u], frame_len(u));
                  end
                  bits_q[u] = '0;
                  nbits[u]  = 0;
               end
               prev_frame[u] = sframe_w[u];
            end
         end
      end
   end

   // Send one word on unit u and check per-cycle framing; dk>0 disturbs d
   // and pulses load_valid in cycle N+dk.
   task automatic send_frame(input int u, input logic [7:0] w, input int dk);
      int nb;
      exp_t e;
      nb = frame_len(u);
      e.unit = u;
      e.word = w;
      sb_q.push_back(e);
      @(negedge clk);
      chk("pre_rdy", {31'd0, rdy_w[u]}, 32'd1);
      d_s[u]  = w;
      lv_s[u] = 1'b1;
      @(posedge clk);
      #1;
      lv_s[u] = 1'b0;
      d_s[u]  = ~w;
      for (int k = 1; k <= nb + 2; k++) begin
         @(negedge clk);
         if (k <= nb) begin
            chk("frm_sframe", {31'd0, sframe_w[u]}, 32'd1);
            chk("frm_rdy",    {31'd0, rdy_w[u]},    32'd0);
            chk("frm_busy",   {31'd0, busy_w[u]},   32'd1);
         end else if (k == nb + 1) begin
            chk("done_pulse",  {31'd0, sdone_w[u]},  32'd1);
            chk("done_rdy",    {31'd0, rdy_w[u]},    32'd0);
            chk("done_sframe", {31'd0, sframe_w[u]}, 32'd0);
         end else begin
            chk("back_rdy",   {31'd0, rdy_w[u]},   32'd1);
            chk("back_sdone", {31'd0, sdone_w[u]}, 32'd0);
            chk("back_busy",  {31'd0, busy_w[u]},  32'd0);
         end
         if (dk != 0 && k == dk) begin
            d_s[u]  = w ^ 8'h5A;
            lv_s[u] = 1'b1;
         end else if (dk != 0 && k == dk + 1) begin
            lv_s[u] = 1'b0;
         end
      end
   endtask

   initial begin
      exp_t e;
      reset_n = 1'b1;
      lv_s    = '0;
      for (int u = 0; u < 4; u++) d_s[u] = '0;
      #2 reset_n = 1'b0;
      #1;
      for (int u = 0; u < 4; u++)
         chk("rst_state", {27'd0, rdy_w[u], busy_w[u], sframe_w[u], sdone_w[u], sdata_w[u]},
             32'b10000);
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("idle_busy", {28'd0, busy_w}, 32'h0);
         chk("idle_rdy",  {28'd0, rdy_w},  32'hF);
      end

      send_frame(0, 8'hA5, 0);
      send_frame(1, 8'h01, 0);
      send_frame(2, 8'h07, 0);
      send_frame(3, 8'h07, 0);
      send_frame(2, 8'hB4, 0);
      send_frame(0, 8'h3C, 4);

      // Back-to-back with load_valid held high across DONE
      e.unit = 0; e.word = 8'hFF; sb_q.push_back(e);
      e.unit = 0; e.word = 8'h00; sb_q.push_back(e);
      @(negedge clk);
      d_s[0]  = 8'hFF;
      lv_s[0] = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 2) d_s[0] = 8'h00;
         if (k <= 9) chk("hold_rdy_low", {31'd0, rdy_w[0]}, 32'd0);
         else        chk("hold_rdy_n10", {31'd0, rdy_w[0]}, 32'd1);
         if (k == 9) chk("hold_done",    {31'd0, sdone_w[0]}, 32'd1);
      end
      @(posedge clk);
      #1 lv_s[0] = 1'b0;
      @(negedge clk);
      chk("hold_second_acc", {31'd0, sframe_w[0]}, 32'd1);
      repeat (9) @(negedge clk);
      chk("hold_back_idle", {31'd0, rdy_w[0]}, 32'd1);

      // Reset in the middle of a frame
      @(negedge clk);
      d_s[0]  = 8'hFF;
      lv_s[0] = 1'b1;
      @(posedge clk);
      #1 lv_s[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_sframe", {31'd0, sframe_w[0]}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("abort_sframe", {31'd0, sframe_w[0]}, 32'd0);
      chk("abort_sdata",  {31'd0, sdata_w[0]},  32'd0);
      chk("abort_busy",   {31'd0, busy_w[0]},   32'd0);
      chk("abort_sdone",  {31'd0, sdone_w[0]},  32'd0);
      chk("abort_rdy",    {31'd0, rdy_w[0]},    32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         chk("post_abort_busy",  {31'd0, busy_w[0]},  32'd0);
         chk("post_abort_sdone", {31'd0, sdone_w[0]}, 32'd0);
      end

      chk("sb_empty", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
